// File: rtl/seq_gen_1011_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_1011_pkg
// Shared definitions for the 1011 serial pattern generator and the attached
// non-overlapping 1011 detector:
//   gen_state_e     - generator FSM encoding (IDLE=0, SHIFT=1, GAP=2, DONE=3)
//   det_state_e     - detector FSM encoding (progress through 1-0-1-1)
//   DEFAULT_PATTERN - pattern sent when the run-time pattern is not selected
// -----------------------------------------------------------------------------
package seq_gen_1011_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } gen_state_e;

    // Detector states name the prefix of 1011 matched so far.
    typedef enum logic [1:0] {
        DET_S0   = 2'd0,
        DET_S1   = 2'd1,
        DET_S10  = 2'd2,
        DET_S101 = 2'd3
    } det_state_e;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage : seq_gen_1011_pkg

// File: rtl/seq_det_1011.sv
// -----------------------------------------------------------------------------
// seq_det_1011
// Non-overlapping 1011 detector, clocked with the generator and fed directly
// from its d_o. After a match the search restarts from scratch, so the final
// 1 of one match is never reused as the first 1 of the next.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-low reset
//   d_i    serial data
//   det_o  registered one-cycle pulse, cycle after the final 1 of 1011
// -----------------------------------------------------------------------------
module seq_det_1011
    import seq_gen_1011_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic det_o
);

    det_state_e r_state;
    det_state_e w_state_nxt;
    logic       r_det;
    logic       w_det_nxt;

    // Detector state and match pulse registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= DET_S0;
            r_det   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_det   <= w_det_nxt;
        end
    end

    // Next-state and match decode.
    always_comb begin
        w_state_nxt = r_state;
        w_det_nxt   = 1'b0;
        case (r_state)
            DET_S0: begin
                if (d_i) begin
                    w_state_nxt = DET_S1;
                end else begin
                    w_state_nxt = DET_S0;
                end
            end
            DET_S1: begin
                if (d_i) begin
                    w_state_nxt = DET_S1;
                end else begin
                    w_state_nxt = DET_S10;
                end
            end
            DET_S10: begin
                if (d_i) begin
                    w_state_nxt = DET_S101;
                end else begin
                    w_state_nxt = DET_S0;
                end
            end
            DET_S101: begin
                if (d_i) begin
                    w_state_nxt = DET_S0;
                    w_det_nxt   = 1'b1;
                end else begin
                    w_state_nxt = DET_S10;
                end
            end
            default: begin
                w_state_nxt = DET_S0;
            end
        endcase
    end

    assign det_o = r_det;

endmodule : seq_det_1011

// File: rtl/seq_gen_cnt.sv
// -----------------------------------------------------------------------------
// seq_gen_cnt
// Loadable down-counter with zero flag. Used by the generator as the bit
// counter (bits left in the current copy) and as the gap counter.
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-low reset, clears the count
//   clr_i       synchronous clear (highest priority)
//   load_i      load load_val_i
//   load_val_i  value to load
//   dec_i       decrement by one; saturates at zero
//   zero_o      count is zero
// -----------------------------------------------------------------------------
module seq_gen_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] r_cnt;

    // Count register: clear > load > decrement > hold.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (dec_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign zero_o = (r_cnt == '0);

endmodule : seq_gen_cnt

// File: rtl/seq_gen_1011.sv
// -----------------------------------------------------------------------------
// seq_gen_1011
// Serial burst generator. On start it latches a pattern (pat_i or PATTERN),
// a repetition count and a gap length, then emits rep copies of the pattern
// MSB-first, separated by gap zero bits, followed by a one-cycle done pulse.
// All outputs come straight from flops.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-low reset
//   start_i    request a burst (only honoured in IDLE)
//   abort_i    synchronous cancel, returns to IDLE without done_o
//   use_pat_i  1 = send pat_i, 0 = send PATTERN
//   pat_i      run-time pattern
//   rep_i      number of copies
//   gap_i      zero bits between copies
//   d_o        serial data
//   valid_o    d_o carries a burst bit (pattern or gap)
//   busy_o     not in IDLE
//   done_o     one-cycle pulse at burst end
//   sent_o     copies completed in current/last burst
// -----------------------------------------------------------------------------
module seq_gen_1011
    import seq_gen_1011_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int               REP_W   = 4,
    parameter int               GAP_W   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             use_pat_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [REP_W-1:0] rep_i,
    input  logic [GAP_W-1:0] gap_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [REP_W-1:0] sent_o
);

    localparam int BCNT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    // The first bit of a copy leaves with the load, so the counter only has
    // to cover the remaining PAT_W-1 bits.
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(PAT_W - 1);

    gen_state_e       r_state;
    gen_state_e       w_state_nxt;
    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] w_pat_nxt;
    logic [PAT_W-1:0] r_shift;
    logic [PAT_W-1:0] w_shift_nxt;
    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_nxt;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;
    logic [REP_W-1:0] r_sent;
    logic [REP_W-1:0] w_sent_nxt;
    logic [REP_W-1:0] w_sent_inc;
    logic [PAT_W-1:0] w_pat_sel;

    logic r_d;
    logic w_d_nxt;
    logic r_valid;
    logic w_valid_nxt;
    logic r_busy;
    logic w_busy_nxt;
    logic r_done;
    logic w_done_nxt;

    logic w_bit_clr;
    logic w_bit_load;
    logic w_bit_dec;
    logic w_bit_zero;
    logic w_gap_clr;
    logic w_gap_load;
    logic w_gap_dec;
    logic w_gap_zero;

    assign w_pat_sel  = use_pat_i ? pat_i : PATTERN;
    assign w_sent_inc = r_sent + REP_W'(1);

    seq_gen_cnt #(
        .W (BCNT_W)
    ) u_bit_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (w_bit_clr),
        .load_i     (w_bit_load),
        .load_val_i (BIT_LAST),
        .dec_i      (w_bit_dec),
        .zero_o     (w_bit_zero)
    );

    // Gap counter is loaded with gap-1 because the first gap bit goes out
    // together with the load.
    seq_gen_cnt #(
        .W (GAP_W)
    ) u_gap_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (w_gap_clr),
        .load_i     (w_gap_load),
        .load_val_i (r_gap - GAP_W'(1)),
        .dec_i      (w_gap_dec),
        .zero_o     (w_gap_zero)
    );

    // FSM state plus the burst context latched at start.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_pat   <= '0;
            r_shift <= '0;
            r_rep   <= '0;
            r_gap   <= '0;
            r_sent  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_shift <= w_shift_nxt;
            r_rep   <= w_rep_nxt;
            r_gap   <= w_gap_nxt;
            r_sent  <= w_sent_nxt;
        end
    end

    // Output flops; their next values are decoded together with the state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_d     <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_d     <= w_d_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state, counter control and next-output decode. The d/valid
    // values computed here are what appear on the outputs in the state
    // being entered, which gives the one-cycle start latency.
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_shift_nxt = r_shift;
        w_rep_nxt   = r_rep;
        w_gap_nxt   = r_gap;
        w_sent_nxt  = r_sent;
        w_d_nxt     = 1'b0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_bit_clr   = 1'b0;
        w_bit_load  = 1'b0;
        w_bit_dec   = 1'b0;
        w_gap_clr   = 1'b0;
        w_gap_load  = 1'b0;
        w_gap_dec   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    w_pat_nxt  = w_pat_sel;
                    w_rep_nxt  = rep_i;
                    w_gap_nxt  = gap_i;
                    w_sent_nxt = '0;
                    if (rep_i != '0) begin
                        w_state_nxt = ST_SHIFT;
                        w_d_nxt     = w_pat_sel[PAT_W-1];
                        w_shift_nxt = w_pat_sel << 1;
                        w_valid_nxt = 1'b1;
                        w_bit_load  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (abort_i) begin
                    w_state_nxt = ST_IDLE;
                    w_bit_clr   = 1'b1;
                    w_gap_clr   = 1'b1;
                end else if (!w_bit_zero) begin
                    w_d_nxt     = r_shift[PAT_W-1];
                    w_shift_nxt = r_shift << 1;
                    w_valid_nxt = 1'b1;
                    w_bit_dec   = 1'b1;
                end else begin
                    // Last bit of this copy is on d_o now.
                    w_sent_nxt = w_sent_inc;
                    if (w_sent_inc == r_rep) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else if (r_gap != '0) begin
                        w_state_nxt = ST_GAP;
                        w_valid_nxt = 1'b1;
                        w_gap_load  = 1'b1;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                        w_d_nxt     = r_pat[PAT_W-1];
                        w_shift_nxt = r_pat << 1;
                        w_valid_nxt = 1'b1;
                        w_bit_load  = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (abort_i) begin
                    w_state_nxt = ST_IDLE;
                    w_bit_clr   = 1'b1;
                    w_gap_clr   = 1'b1;
                end else if (!w_gap_zero) begin
                    w_valid_nxt = 1'b1;
                    w_gap_dec   = 1'b1;
                end else begin
                    w_state_nxt = ST_SHIFT;
                    w_d_nxt     = r_pat[PAT_W-1];
                    w_shift_nxt = r_pat << 1;
                    w_valid_nxt = 1'b1;
                    w_bit_load  = 1'b1;
                end
            end

            ST_DONE: begin
                // Abort or not, DONE always ends in IDLE after one cycle.
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_bit_clr   = 1'b1;
                w_gap_clr   = 1'b1;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign d_o     = r_d;
    assign valid_o = r_valid;
    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign sent_o  = r_sent;

endmodule : seq_gen_1011

// File: tb/tb_seq_gen_1011.sv
// -----------------------------------------------------------------------------
// tb_seq_gen_1011
// Directed bench for seq_gen_1011 with the 1011 detector attached to d_o.
// -----------------------------------------------------------------------------
module tb_seq_gen_1011;

    logic       clk_i;
    logic       rst_i;
    logic       start_i;
    logic       abort_i;
    logic       use_pat_i;
    logic [3:0] pat_i;
    logic [3:0] rep_i;
    logic [2:0] gap_i;
    logic       d_o;
    logic       valid_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] sent_o;
    logic       w_det;

    int n_checks;
    int n_errors;

    // Per-window observations gathered by collect().
    logic [31:0] stream;
    int          nvalid;
    int          ndone;
    int          nbusy;
    int          done_at;
    int          first_v;
    int          det_cnt;

    seq_gen_1011 u_dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .use_pat_i (use_pat_i),
        .pat_i     (pat_i),
        .rep_i     (rep_i),
        .gap_i     (gap_i),
        .d_o       (d_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .sent_o    (sent_o)
    );

    seq_det_1011 u_det (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (d_o),
        .det_o (w_det)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge; count detector pulses.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (w_det === 1'b1) det_cnt++;
    endtask

    task automatic start_burst(input logic use_p, input logic [3:0] pat,
                               input logic [3:0] rep, input logic [2:0] gap);
        use_pat_i = use_p;
        pat_i     = pat;
        rep_i     = rep;
        gap_i     = gap;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
    endtask

    // Observe n cycles, starting with the cycle after the accepting edge.
    // start_i pulses on odd cycles below 'hold' to exercise ignored starts.
    task automatic collect(input int n, input int hold);
        stream  = 32'd0;
        nvalid  = 0;
        ndone   = 0;
        nbusy   = 0;
        done_at = 0;
        first_v = 0;
        det_cnt = 0;
        for (int i = 1; i <= n; i++) begin
            if (valid_o === 1'b1) begin
                stream = {stream[30:0], d_o};
                nvalid++;
                if (first_v == 0) first_v = i;
            end
            if (done_o === 1'b1) begin
                ndone++;
                done_at = i;
            end
            if (busy_o === 1'b1) nbusy++;
            start_i = (i < hold) ? 1'(i % 2) : 1'b0;
            tick();
        end
        start_i = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        det_cnt   = 0;
        start_i   = 1'b0;
        abort_i   = 1'b0;
        use_pat_i = 1'b0;
        pat_i     = 4'd0;
        rep_i     = 4'd0;
        gap_i     = 3'd0;
        rst_i     = 1'b1;
        #1 rst_i  = 1'b0;
        #2;
        chk("rst_d",     32'(d_o),     32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_busy",  32'(busy_o),  32'd0);
        chk("rst_done",  32'(done_o),  32'd0);
        chk("rst_sent",  32'(sent_o),  32'd0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();

        // Default pattern, rep=3, gap=2.
        start_burst(1'b0, 4'd0, 4'd3, 3'd2);
        collect(24, 0);
        chk("def_stream", stream, 32'h0000_B2CB);
        chk("def_nvalid", 32'(nvalid), 32'd16);
        chk("def_first",  32'(first_v), 32'd1);
        chk("def_ndone",  32'(ndone), 32'd1);
        chk("def_doneat", 32'(done_at), 32'd17);
        chk("def_nbusy",  32'(nbusy), 32'd17);
        chk("def_sent",   32'(sent_o), 32'd3);
        chk("def_det",    32'(det_cnt), 32'd3);

        // Run-time pattern 1101, rep=2, gap=0; inputs scrambled mid-burst.
        start_burst(1'b1, 4'b1101, 4'd2, 3'd0);
        use_pat_i = 1'b0;
        pat_i     = 4'b0000;
        rep_i     = 4'd7;
        gap_i     = 3'd5;
        collect(16, 0);
        chk("pat_stream", stream, 32'h0000_00DD);
        chk("pat_nvalid", 32'(nvalid), 32'd8);
        chk("pat_ndone",  32'(ndone), 32'd1);
        chk("pat_doneat", 32'(done_at), 32'd9);
        chk("pat_sent",   32'(sent_o), 32'd2);
        chk("pat_det",    32'(det_cnt), 32'd1);

        // rep=0: one busy/done cycle, no bits.
        start_burst(1'b0, 4'd0, 4'd0, 3'd3);
        collect(8, 0);
        chk("r0_nvalid", 32'(nvalid), 32'd0);
        chk("r0_ndone",  32'(ndone), 32'd1);
        chk("r0_doneat", 32'(done_at), 32'd1);
        chk("r0_nbusy",  32'(nbusy), 32'd1);
        chk("r0_sent",   32'(sent_o), 32'd0);

        // Abort on the 3rd bit of the 2nd copy (cycle 8), rep=4, gap=1.
        start_burst(1'b0, 4'd0, 4'd4, 3'd1);
        for (int i = 0; i < 7; i++) tick();
        chk("ab_pre_d",     32'(d_o),     32'd1);
        chk("ab_pre_valid", 32'(valid_o), 32'd1);
        chk("ab_pre_sent",  32'(sent_o),  32'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("ab_valid", 32'(valid_o), 32'd0);
        chk("ab_busy",  32'(busy_o),  32'd0);
        chk("ab_d",     32'(d_o),     32'd0);
        chk("ab_done",  32'(done_o),  32'd0);
        chk("ab_sent",  32'(sent_o),  32'd1);
        collect(8, 0);
        chk("ab_after_valid", 32'(nvalid), 32'd0);
        chk("ab_after_done",  32'(ndone),  32'd0);

        // abort together with start in IDLE must not start.
        rep_i   = 4'd2;
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("abst_busy",  32'(busy_o),  32'd0);
        chk("abst_valid", 32'(valid_o), 32'd0);

        // Asynchronous reset in the middle of a gap.
        start_burst(1'b0, 4'd0, 4'd2, 3'd3);
        for (int i = 0; i < 4; i++) tick();
        chk("rg_pre_valid", 32'(valid_o), 32'd1);
        chk("rg_pre_d",     32'(d_o),     32'd0);
        chk("rg_pre_busy",  32'(busy_o),  32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("rg_valid", 32'(valid_o), 32'd0);
        chk("rg_busy",  32'(busy_o),  32'd0);
        chk("rg_sent",  32'(sent_o),  32'd0);
        tick();
        rst_i = 1'b1;
        collect(6, 0);
        chk("rg_idle_busy", 32'(nbusy), 32'd0);
        chk("rg_idle_done", 32'(ndone), 32'd0);
        start_burst(1'b0, 4'd0, 4'd1, 3'd2);
        collect(10, 0);
        chk("rg_stream", stream, 32'h0000_000B);
        chk("rg_nvalid", 32'(nvalid), 32'd4);
        chk("rg_ndone",  32'(ndone), 32'd1);
        chk("rg_doneat", 32'(done_at), 32'd5);
        chk("rg_sent",   32'(sent_o), 32'd1);

        // Repeated start pulses during a rep=2, gap=1 burst.
        start_burst(1'b0, 4'd0, 4'd2, 3'd1);
        collect(24, 11);
        chk("rs_stream", stream, 32'h0000_016B);
        chk("rs_nvalid", 32'(nvalid), 32'd9);
        chk("rs_ndone",  32'(ndone), 32'd1);
        chk("rs_doneat", 32'(done_at), 32'd10);
        chk("rs_nbusy",  32'(nbusy), 32'd10);
        chk("rs_sent",   32'(sent_o), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_gen_1011
